// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side and memory-bus-side signals of the IF/MEM memory bus arbiter.
// The arbiter connects through slave; the pipeline/bus environment uses master.
interface mem_bus_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic          if_ce_i;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_data_o;
   logic          if_stallreq_o;

   logic          mem_ce_i;
   logic          mem_we_i;
   logic [AW-1:0] mem_addr_i;
   logic [SW-1:0] mem_sel_i;
   logic [DW-1:0] mem_data_i;
   logic [DW-1:0] mem_data_o;
   logic          mem_stallreq_o;

   logic          bus_ce_o;
   logic          bus_we_o;
   logic [AW-1:0] bus_addr_o;
   logic [SW-1:0] bus_sel_o;
   logic [DW-1:0] bus_data_o;
   logic [DW-1:0] bus_data_i;
   logic          bus_ack_i;
   logic          bus_err_o;

   modport slave (
      input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
             bus_data_i, bus_ack_i,
      output if_data_o, if_stallreq_o, mem_data_o, mem_stallreq_o,
             bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o, bus_err_o
   );

   modport master (
      output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
             bus_data_i, bus_ack_i,
      input  if_data_o, if_stallreq_o, mem_data_o, mem_stallreq_o,
             bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o, bus_err_o
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and the MEM stage,
// with fixed MEM priority, per-port read holding registers and a wait-cycle watchdog.
module mem_bus_arbiter #(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_bus_arbiter_if.slave   bif
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {OWN_IF, OWN_MEM} owner_t;

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          bus_ce_q, bus_ce_d;
   logic          bus_we_q, bus_we_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [SW-1:0] bus_sel_q, bus_sel_d;
   logic [DW-1:0] bus_data_q, bus_data_d;
   logic [DW-1:0] if_data_q, if_data_d;
   logic [DW-1:0] mem_data_q, mem_data_d;
   logic          err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         wait_q     <= '0;
         bus_ce_q   <= 1'b0;
         bus_we_q   <= 1'b0;
         bus_addr_q <= '0;
         bus_sel_q  <= '0;
         bus_data_q <= '0;
         if_data_q  <= '0;
         mem_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wait_q     <= wait_d;
         bus_ce_q   <= bus_ce_d;
         bus_we_q   <= bus_we_d;
         bus_addr_q <= bus_addr_d;
         bus_sel_q  <= bus_sel_d;
         bus_data_q <= bus_data_d;
         if_data_q  <= if_data_d;
         mem_data_q <= mem_data_d;
         err_q      <= err_d;
      end
   end

   // Grant, completion and watchdog; err is a single-cycle pulse so it defaults low.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wait_d     = wait_q;
      bus_ce_d   = bus_ce_q;
      bus_we_d   = bus_we_q;
      bus_addr_d = bus_addr_q;
      bus_sel_d  = bus_sel_q;
      bus_data_d = bus_data_q;
      if_data_d  = if_data_q;
      mem_data_d = mem_data_q;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bif.mem_ce_i) begin
               state_d    = BUSY;
               owner_d    = OWN_MEM;
               wait_d     = '0;
               bus_ce_d   = 1'b1;
               bus_we_d   = bif.mem_we_i;
               bus_addr_d = bif.mem_addr_i;
               bus_sel_d  = bif.mem_sel_i;
               bus_data_d = bif.mem_data_i;
            end else if (bif.if_ce_i) begin
               state_d    = BUSY;
               owner_d    = OWN_IF;
               wait_d     = '0;
               bus_ce_d   = 1'b1;
               bus_we_d   = 1'b0;
               bus_addr_d = bif.if_addr_i;
               bus_sel_d  = {SW{1'b1}};
               bus_data_d = '0;
            end
         end
         BUSY: begin
            if (bif.bus_ack_i) begin
               state_d  = DONE;
               bus_ce_d = 1'b0;
               bus_we_d = 1'b0;
               if (!bus_we_q) begin
                  if (owner_q == OWN_MEM) mem_data_d = bif.bus_data_i;
                  else                    if_data_d  = bif.bus_data_i;
               end
            end else if (wait_q == LAST_WAIT) begin
               // Watchdog abort: reads return zero so no stale data looks valid.
               state_d  = DONE;
               bus_ce_d = 1'b0;
               err_d    = 1'b1;
               if (!bus_we_q) begin
                  if (owner_q == OWN_MEM) mem_data_d = '0;
                  else                    if_data_d  = '0;
               end
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bif.bus_ce_o   = bus_ce_q;
   assign bif.bus_we_o   = bus_we_q;
   assign bif.bus_addr_o = bus_addr_q;
   assign bif.bus_sel_o  = bus_sel_q;
   assign bif.bus_data_o = bus_data_q;
   assign bif.if_data_o  = if_data_q;
   assign bif.mem_data_o = mem_data_q;
   assign bif.bus_err_o  = err_q;

   // Stall releases only in the DONE cycle of the port's own access.
   assign bif.if_stallreq_o  = rst & bif.if_ce_i  & ~((state_q == DONE) & (owner_q == OWN_IF));
   assign bif.mem_stallreq_o = rst & bif.mem_ce_i & ~((state_q == DONE) & (owner_q == OWN_MEM));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written timeout/reset
// sequences and random traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;
   localparam int unsigned T = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bif ();
   mem_bus_arbiter #(.TimeoutCycles(T)) dut (.clk(clk), .rst(rst), .bif(bif));

   int checks   = 0;
   int failures = 0;

   typedef logic [136:0] obs_t;

   typedef struct {
      logic        rst, if_ce;
      logic [31:0] if_addr;
      logic        mem_ce, mem_we;
      logic [31:0] mem_addr;
      logic [3:0]  mem_sel;
      logic [31:0] mem_wdata;
      logic        ack;
      logic [31:0] rdata;
      obs_t        exp;
   } vec_t;

   function automatic vec_t mk(logic r, logic ic, logic [31:0] ia, logic mc, logic mw,
                               logic [31:0] ma, logic [3:0] ms, logic [31:0] md, logic ak,
                               logic [31:0] rd, logic eis, logic ems, logic ece, logic ewe,
                               logic [31:0] ea, logic [3:0] es, logic [31:0] ewd,
                               logic [31:0] eid, logic [31:0] emd, logic eerr);
      vec_t v;
      v.rst = r; v.if_ce = ic; v.if_addr = ia; v.mem_ce = mc; v.mem_we = mw;
      v.mem_addr = ma; v.mem_sel = ms; v.mem_wdata = md; v.ack = ak; v.rdata = rd;
      v.exp = {eis, ems, ece, ewe, ea, es, ewd, eid, emd, eerr};
      return v;
   endfunction

   function automatic obs_t observe();
      return {bif.if_stallreq_o, bif.mem_stallreq_o, bif.bus_ce_o, bif.bus_we_o,
              bif.bus_addr_o, bif.bus_sel_o, bif.bus_data_o, bif.if_data_o,
              bif.mem_data_o, bif.bus_err_o};
   endfunction

   // Reference model: one outstanding access record, timeout measured in elapsed cycles.
   typedef struct {
      bit          valid;
      bit          is_mem;
      bit          we;
      int          start;
   } acc_t;

   acc_t        m_acc;
   bit          m_done, m_done_mem, m_err;
   logic        m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_sel;
   logic [31:0] m_hold [2];
   int          cyc = 0;

   function automatic obs_t model_obs();
      logic ist, mst;
      ist = rst & bif.if_ce_i  & ~(m_done & ~m_done_mem);
      mst = rst & bif.mem_ce_i & ~(m_done & m_done_mem);
      return {ist, mst, logic'(m_acc.valid), m_we, m_addr, m_sel, m_wdata,
              m_hold[0], m_hold[1], logic'(m_err)};
   endfunction

   task automatic finish_access(input bit abort, input logic [31:0] d);
      m_acc.valid = 1'b0;
      m_done      = 1'b1;
      m_done_mem  = m_acc.is_mem;
      m_err       = abort;
      if (!abort) m_we = 1'b0;
      if (!m_acc.we) m_hold[int'(m_acc.is_mem)] = d;
   endtask

   task automatic model_step();
      if (rst !== 1'b1) begin
         m_acc = '{default: 0};
         m_done = 1'b0; m_done_mem = 1'b0; m_err = 1'b0;
         m_we = 1'b0; m_addr = '0; m_wdata = '0; m_sel = '0;
         m_hold[0] = '0; m_hold[1] = '0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_err  = 1'b0;
      end else if (m_acc.valid) begin
         if (bif.bus_ack_i) finish_access(1'b0, bif.bus_data_i);
         else if (cyc - m_acc.start == int'(T)) finish_access(1'b1, 32'h0);
      end else if (bif.mem_ce_i || bif.if_ce_i) begin
         m_acc.valid  = 1'b1;
         m_acc.is_mem = bif.mem_ce_i;
         m_acc.we     = bif.mem_ce_i ? bif.mem_we_i : 1'b0;
         m_acc.start  = cyc;
         m_we    = m_acc.we;
         m_addr  = bif.mem_ce_i ? bif.mem_addr_i : bif.if_addr_i;
         m_sel   = bif.mem_ce_i ? bif.mem_sel_i  : 4'hF;
         m_wdata = bif.mem_ce_i ? bif.mem_data_i : 32'h0;
      end
      cyc++;
   endtask

   task automatic check_obs(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic finish_cycle();
      check_obs($sformatf("model@%0d", cyc), observe(), model_obs());
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      rst            = v.rst;
      bif.if_ce_i    = v.if_ce;
      bif.if_addr_i  = v.if_addr;
      bif.mem_ce_i   = v.mem_ce;
      bif.mem_we_i   = v.mem_we;
      bif.mem_addr_i = v.mem_addr;
      bif.mem_sel_i  = v.mem_sel;
      bif.mem_data_i = v.mem_wdata;
      bif.bus_ack_i  = v.ack;
      bif.bus_data_i = v.rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int   ce_cnt, err_cnt, after;
      bit   err_seen;
      int   ack_pct;

      apply(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      @(posedge clk); @(posedge clk); #1;
      model_step();

      // rst, if_ce, if_addr, mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, ack, rdata |
      // if_stall, mem_stall, bus_ce, bus_we, bus_addr, bus_sel, bus_wdata, if_data, mem_data, err
      vecs.push_back(mk(0,1,32'h40,1,0,32'h2000,4'hF,0,0,0,            0,0,0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,32'h40,0,0,0,0,0,0,0,                      1,0,0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,32'h40,0,0,0,0,0,0,0,                      1,0,1,0,32'h40,4'hF,0,0,0,0));
      vecs.push_back(mk(1,1,32'h40,0,0,0,0,0,1,32'h2401_0005,          1,0,1,0,32'h40,4'hF,0,0,0,0));
      vecs.push_back(mk(1,1,32'h40,0,0,0,0,0,0,0,                      0,0,0,0,32'h40,4'hF,0,32'h2401_0005,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,                           0,0,0,0,32'h40,4'hF,0,32'h2401_0005,0,0));
      vecs.push_back(mk(1,1,32'h100,1,0,32'h2000,4'hF,0,0,0,           1,1,0,0,32'h40,4'hF,0,32'h2401_0005,0,0));
      vecs.push_back(mk(1,1,32'h100,1,0,32'h2000,4'hF,0,1,32'h1111_2222, 1,1,1,0,32'h2000,4'hF,0,32'h2401_0005,0,0));
      vecs.push_back(mk(1,1,32'h100,1,0,32'h2000,4'hF,0,0,0,           1,0,0,0,32'h2000,4'hF,0,32'h2401_0005,32'h1111_2222,0));
      vecs.push_back(mk(1,1,32'h100,0,0,0,0,0,0,0,                     1,0,0,0,32'h2000,4'hF,0,32'h2401_0005,32'h1111_2222,0));
      vecs.push_back(mk(1,1,32'h100,0,0,0,0,0,1,32'h3333_4444,         1,0,1,0,32'h100,4'hF,0,32'h2401_0005,32'h1111_2222,0));
      vecs.push_back(mk(1,1,32'h100,0,0,0,0,0,0,0,                     0,0,0,0,32'h100,4'hF,0,32'h3333_4444,32'h1111_2222,0));
      vecs.push_back(mk(1,0,0,1,1,32'h10,4'h3,32'hDEAD_BEEF,0,0,       0,1,0,0,32'h100,4'hF,0,32'h3333_4444,32'h1111_2222,0));
      vecs.push_back(mk(1,0,0,1,1,32'h10,4'h3,32'hDEAD_BEEF,0,0,       0,1,1,1,32'h10,4'h3,32'hDEAD_BEEF,32'h3333_4444,32'h1111_2222,0));
      vecs.push_back(mk(1,0,0,1,1,32'h10,4'h3,32'hDEAD_BEEF,1,32'h5555_5555, 0,1,1,1,32'h10,4'h3,32'hDEAD_BEEF,32'h3333_4444,32'h1111_2222,0));
      vecs.push_back(mk(1,0,0,1,1,32'h10,4'h3,32'hDEAD_BEEF,0,0,       0,0,0,0,32'h10,4'h3,32'hDEAD_BEEF,32'h3333_4444,32'h1111_2222,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,1,32'h66,                      0,0,0,0,32'h10,4'h3,32'hDEAD_BEEF,32'h3333_4444,32'h1111_2222,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,                           0,0,0,0,32'h10,4'h3,32'hDEAD_BEEF,32'h3333_4444,32'h1111_2222,0));

      foreach (vecs[i]) begin
         apply(vecs[i]);
         @(negedge clk);
         check_obs($sformatf("vec%0d", i), observe(), vecs[i].exp);
         finish_cycle();
      end

      // Watchdog abort on an unanswered MEM load.
      apply(mk(1,0,0,1,0,32'h3000,4'hF,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      ce_cnt = 0; err_cnt = 0; err_seen = 1'b0; after = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bif.bus_ce_o === 1'b1) ce_cnt++;
         if (bif.bus_err_o === 1'b1) begin
            err_cnt++;
            err_seen = 1'b1;
            check_val("timeout_stall_in_done", 32'(bif.mem_stallreq_o), 32'h0);
            check_val("timeout_mem_data", bif.mem_data_o, 32'h0);
         end
         finish_cycle();
         if (err_seen) begin
            bif.mem_ce_i = 1'b0;
            after++;
            if (after >= 3) break;
         end
      end
      check_val("timeout_ce_cycles", 32'(ce_cnt), 32'(T));
      check_val("timeout_err_pulses", 32'(err_cnt), 32'h1);

      // Reset in the middle of a pending fetch, then a stray late ack.
      apply(mk(1,1,32'h200,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      repeat (3) begin
         @(negedge clk);
         finish_cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_stall_forced", 32'(bif.if_stallreq_o), 32'h0);
      check_val("rst_busy_before", 32'(bif.bus_ce_o), 32'h1);
      finish_cycle();
      rst = 1'b1; bif.if_ce_i = 1'b0; bif.bus_ack_i = 1'b1; bif.bus_data_i = 32'hDEAD_C0DE;
      @(negedge clk);
      check_val("rst_mid_busy_ce", 32'(bif.bus_ce_o), 32'h0);
      check_val("rst_if_data", bif.if_data_o, 32'h0);
      finish_cycle();
      bif.bus_ack_i = 1'b0; bif.if_ce_i = 1'b1; bif.if_addr_i = 32'h204;
      @(negedge clk);
      check_val("late_ack_ignored", bif.if_data_o, 32'h0);
      finish_cycle();
      bif.bus_ack_i = 1'b1; bif.bus_data_i = 32'h0BAD_F00D;
      @(negedge clk);
      check_val("restart_addr", bif.bus_addr_o, 32'h204);
      finish_cycle();
      bif.bus_ack_i = 1'b0;
      @(negedge clk);
      check_val("restart_data", bif.if_data_o, 32'h0BAD_F00D);
      check_val("restart_stall_low", 32'(bif.if_stallreq_o), 32'h0);
      finish_cycle();

      // Random traffic; some windows never ack to exercise the watchdog.
      ack_pct = 40;
      for (int n = 0; n < 3000; n++) begin
         if (n % 128 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 0 : 40;
         rst            = ($urandom_range(0, 199) != 0);
         bif.if_ce_i    = ($urandom_range(0, 2) != 0);
         bif.if_addr_i  = 32'($urandom);
         bif.mem_ce_i   = 1'($urandom_range(0, 1));
         bif.mem_we_i   = 1'($urandom_range(0, 1));
         bif.mem_addr_i = 32'($urandom);
         bif.mem_sel_i  = 4'($urandom);
         bif.mem_data_i = 32'($urandom);
         bif.bus_ack_i  = ($urandom_range(0, 99) < ack_pct);
         bif.bus_data_i = 32'($urandom);
         @(negedge clk);
         finish_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter that shares a single-port, variable-latency memory bus between the instruction-fetch port and the MEM-stage load/store port of the 5-stage MIPS pipeline. Grants one requester at a time, drives registered bus signals, holds the requester stalled until the bus acknowledges, and returns read data in per-port holding registers. Includes a wait-cycle watchdog that aborts hung accesses. Sits between the pipeline (IF, MEM, stall controller) and the external SRAM/bus interface.

## Interface
- TimeoutCycles, 16: BUSY cycles without ack before abort; legal 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- if_ce_i  in  1  instruction-fetch request (read only).
- if_addr_i  in  32  fetch address.
- if_data_o  out  32  fetched instruction (holding register).
- if_stallreq_o  out  1  stall request for IF.
- mem_ce_i  in  1  MEM-stage request.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  data address.
- mem_sel_i  in  4  byte enables.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data (holding register).
- mem_stallreq_o  out  1  stall request for MEM.
- bus_ce_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  32  bus address.
- bus_sel_o  out  4  bus byte enables.
- bus_data_o  out  32  bus write data.
- bus_data_i  in  32  bus read data, valid with ack.
- bus_ack_i  in  1  bus completion.
- bus_err_o  out  1  one-cycle pulse: access aborted by watchdog.

## Operation
- States: IDLE, BUSY, DONE; owner register (IF or MEM); 8-bit wait counter.
- IDLE: if mem_ce_i=1, owner<=MEM; else if if_ce_i=1, owner<=IF; either way -> BUSY. Data port has fixed priority. No request: stay IDLE.
- IDLE->BUSY edge latches bus_addr/we/sel/data from the granted port and sets bus_ce_o=1; wait counter <= 0. IF grant: bus_we_o=0, bus_sel_o=4'b1111, bus_data_o=0.
- BUSY: bus outputs held stable. bus_ack_i=1 -> DONE, bus_ce_o<=0, bus_we_o<=0; if the access is a read, bus_data_i is loaded into the owner's holding register. No ack: counter increments; when counter = TimeoutCycles-1 and no ack -> DONE with error flag, bus_ce_o<=0, owner's holding register <= 0 on reads.
- DONE: one cycle, no new grant; bus_err_o=1 only if aborted. -> IDLE.
- Stores never modify mem_data_o. Holding registers keep value until the next completed read of the same port.
- if_stallreq_o = if_ce_i AND NOT(state=DONE AND owner=IF); mem_stallreq_o likewise for MEM. Combinational; both forced 0 while rst=0.
- Requester dropping ce during BUSY: bus access still completes (no bus abort); read result still loaded; stall output follows ce.
- Ack in IDLE or DONE is ignored.

## Timing
- Reset (rst=0 at edge): state IDLE, owner IF, counter 0, bus_ce_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_data_o=0, if_data_o=0, mem_data_o=0, bus_err_o=0. Reset mid-BUSY drops bus_ce_o at that edge.
- Request seen in IDLE at cycle T: bus_ce_o=1 from T+1; ack at T+k (k≥1) -> DONE at T+k+1, stall low in T+k+1, data valid from T+k+1.
- Zero-wait memory (ack in first BUSY cycle): 3-cycle turnaround, stall high for 2 cycles.
- Simultaneous IF and MEM requests: MEM served first; IF granted earliest at the IDLE cycle after MEM's DONE.
- Timeout: bus_ce_o high for exactly TimeoutCycles cycles, then DONE with bus_err_o pulse.

## Test plan
- Reset: hold rst=0 with if_ce_i=1, mem_ce_i=1 -> all outputs 0, stalls 0, bus_ce_o=0.
- IF fetch, addr 0x0000_0040, ack 2 cycles after bus_ce_o rises with data 0x2401_0005 -> if_stallreq_o high 3 cycles, then low 1 cycle, if_data_o=0x2401_0005.
- Concurrent: IF 0x100 and MEM load 0x2000 same cycle -> first bus cycle addr 0x2000 we=0; IF access starts cycle after MEM DONE+IDLE; IF stalled throughout.
- Store: mem_we_i=1, addr 0x10, sel 4'b0011, data 0xDEAD_BEEF -> bus_we_o=1, bus_sel_o=0011, bus_data_o=0xDEADBEEF; mem_data_o unchanged.
- Timeout: TimeoutCycles=16, no ack on MEM load -> bus_ce_o high 16 cycles, bus_err_o 1-cycle pulse, mem_data_o=0, mem_stallreq_o low in DONE.
- Reset mid-BUSY: rst=0 during wait -> bus_ce_o=0 next edge; after release, late ack ignored, new request starts cleanly from IDLE.
